adc_serial_responder: RTL and testbench
=======================================

// Module: adc_serial_responder
// PURPOSE
//  Slave end of the 3-wire serial ADC link (ADC clock, CS, serial data) that the ADC reader drives.
//  Emulates one 8-bit serial ADC. Latches a parallel sample (e.g. PhaseA_Analog from the harmonic
//  generator) at CS fall, then shifts it out MSB-first on the master's ADC clock.
//  Six instances (3 V, 3 I) close the loop on-board, so capture, storage and GUI run with no load circuit.
// PARAMETERS
//  IN_W         10  width of parallel sample_in
//  DATA_W        8  bits per frame; the top DATA_W bits of sample_in are sent (truncation, no rounding)
//  LEAD_CYCLES   1  null (0) bits driven before the MSB, emulating MUX settling
//  SYNC_STAGES   2  flip-flops in the synchroniser on ADC_clk and CS
// PORTS
//  clk          in   1       system clock; only clock in the block
//  reset        in   1       synchronous, active-low reset
//  ADC_clk      in   1       serial clock from master, asynchronous to clk
//  CS           in   1       chip select from master, active-low, asynchronous
//  sample_in    in   IN_W    parallel value to transmit; sampled at CS fall
//  DATA_Out     out  1       serial data to master; registered
//  busy         out  1       high from CS-fall detect until return to IDLE
//  frame_done   out  1       1-clk pulse when the last bit (bit 0) has been held for one full ADC_clk period
//  frame_error  out  1       1-clk pulse when CS rises before frame completion
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): state=IDLE, DATA_Out=0, busy=0, frame_done=0, frame_error=0,
//    shift register and counters cleared. Reset mid-frame aborts the frame with no error pulse.
//  - ADC_clk and CS each pass through SYNC_STAGES FFs plus one history FF.
//    Edge detects are 1-clk pulses; latency from pin to action is SYNC_STAGES+1 clk.
//  - Requirement on master: each ADC_clk phase >= SYNC_STAGES+2 clk periods. CS falls >= 1 full
//    ADC_clk period before the first falling edge.
//  - Data is launched on ADC_clk falling edges; the master samples on rising edges.
//  - FSM states: IDLE, LEAD, SHIFT, DONE.
//    IDLE : DATA_Out=0. On CS fall: sreg <= sample_in[IN_W-1 -: DATA_W]; cnt <= 0; busy <= 1.
//           Go to LEAD, or to SHIFT with MSB driven immediately if LEAD_CYCLES==0.
//    LEAD : DATA_Out=0. Each ADC_clk fall increments cnt. The fall that brings cnt to LEAD_CYCLES
//           drives sreg[DATA_W-1] and moves to SHIFT with bit index = DATA_W-1.
//    SHIFT: each ADC_clk fall drives the next lower bit. The fall after bit 0 was driven forces
//           DATA_Out=0, pulses frame_done and moves to DONE.
//    DONE : DATA_Out=0; further ADC_clk edges ignored. On CS rise go to IDLE, busy=0, no error.
//  - Total falling edges per frame = LEAD_CYCLES + DATA_W + 1.
//  - CS rise in LEAD or SHIFT: frame_error pulses, DATA_Out=0, IDLE, busy=0 on the same cycle.
//  - Simultaneous CS-rise and ADC_clk-fall detect: CS wins (abort/close); the clock edge is ignored.
//  - CS fall seen while not IDLE (glitch): ignored.
//  - sample_in changes after latch: no effect on the frame in flight.
//  - ADC_clk edges while CS high: ignored. No wrap-around: cnt saturates and the FSM leaves SHIFT.
// STRUCTURE
//  - Shared package adc_link_pkg: state encodings, default DATA_W/IN_W/LEAD_CYCLES, CS active level.
//    The ADC reader imports the same package so both ends agree on frame length.
//  - One sub-module, adc_edge_sync: SYNC_STAGES synchroniser plus rise/fall pulse outputs;
//    instantiated twice (ADC_clk, CS).
//  - FSM, shift register and counter live in this module.
// TESTING
//  - Hold reset low 3 clk with ADC_clk/CS toggling -> DATA_Out=0, busy=0, no pulses throughout.
//  - sample_in=10'h2D4 (top8=8'hB5); ADC_clk half-period 8 clk; CS low, 10 ADC_clk cycles ->
//    rising-edge samples 0,1,0,1,1,0,1,0,1 then 0; frame_done pulses exactly once; CS rise -> busy=0,
//    no frame_error.
//  - Same setup, CS raised after 4 data bits -> frame_error single 1-clk pulse, no frame_done,
//    DATA_Out=0, IDLE.
//  - Latch 10'h000, change sample_in to 10'h3FF mid-frame -> all 8 data bits 0. Next frame -> 8'hFF.
//  - Back-to-back frames with 1 ADC_clk of CS-high gap -> both decoded correctly, two frame_done pulses.
//  - Assert reset during bit 5 -> next clk DATA_Out=0, busy=0, no error pulse. Following frame is correct.

Source files
------------

// File: rtl/adc_link_pkg.sv
// Shared definitions for both ends of the 3-wire serial ADC link.
// Frame geometry, FSM state encoding and chip-select active level.
package adc_link_pkg;

  localparam int ADC_IN_W        = 10;
  localparam int ADC_DATA_W      = 8;
  localparam int ADC_LEAD_CYCLES = 1;
  localparam int ADC_SYNC_STAGES = 2;

  localparam logic ADC_CS_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } adc_state_e;

  // ADC_clk falling edges the master issues per frame.
  function automatic int adc_frame_falls(int lead, int dw);
    return lead + dw + 1;
  endfunction

endpackage

// File: rtl/adc_edge_sync.sv
// Synchroniser for one asynchronous pin plus a history flop.
// Ports: clk, reset (sync, active-low), d (async pin),
// level (synchronised value), toggle (1-clk pulse on any edge).
module adc_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic toggle
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[STAGES-1];
    end
  end

  // Rise is toggle & level, fall is toggle & ~level.
  assign level  = sync_q[STAGES-1];
  assign toggle = level ^ hist_q;

endmodule

// File: rtl/adc_serial_responder.sv
// Slave end of the serial ADC link: latches sample_in at CS assert
// and shifts the top DATA_W bits out MSB-first on ADC_clk falls.
// Ports: clk, reset (sync, active-low), ADC_clk, CS, sample_in,
// DATA_Out, busy, frame_done, frame_error.
module adc_serial_responder
  import adc_link_pkg::*;
#(
  parameter int IN_W        = ADC_IN_W,
  parameter int DATA_W      = ADC_DATA_W,
  parameter int LEAD_CYCLES = ADC_LEAD_CYCLES,
  parameter int SYNC_STAGES = ADC_SYNC_STAGES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ADC_clk,
  input  logic            CS,
  input  logic [IN_W-1:0] sample_in,
  output logic            DATA_Out,
  output logic            busy,
  output logic            frame_done,
  output logic            frame_error
);

  localparam int CNT_W = (LEAD_CYCLES > 1) ?
                         $clog2(LEAD_CYCLES + 1) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic clk_lvl, clk_tgl;
  logic cs_lvl, cs_tgl;

  adc_edge_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_clk_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (ADC_clk),
    .level  (clk_lvl),
    .toggle (clk_tgl)
  );

  adc_edge_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (~ADC_CS_ACTIVE)
  ) u_cs_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (CS),
    .level  (cs_lvl),
    .toggle (cs_tgl)
  );

  logic clk_fall, cs_on, cs_off;
  assign clk_fall = clk_tgl & ~clk_lvl;
  assign cs_on    = cs_tgl & (cs_lvl == ADC_CS_ACTIVE);
  assign cs_off   = cs_tgl & (cs_lvl != ADC_CS_ACTIVE);

  logic [DATA_W-1:0] latch;
  assign latch = sample_in[IN_W-1 -: DATA_W];

  adc_state_e        state_q;
  logic [DATA_W-1:0] sreg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BIT_W-1:0]  bit_q;
  logic              data_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  // CS deassert is tested before the clock fall in every
  // active state, so it wins when both land on one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          data_q <= 1'b0;
          if (cs_on) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            if (LEAD_CYCLES == 0) begin
              data_q  <= latch[DATA_W-1];
              sreg_q  <= latch << 1;
              bit_q   <= BIT_W'(DATA_W - 1);
              state_q <= ST_SHIFT;
            end else begin
              sreg_q  <= latch;
              state_q <= ST_LEAD;
            end
          end
        end
        ST_LEAD: begin
          if (cs_off) begin
            err_q   <= 1'b1;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (clk_fall) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(LEAD_CYCLES - 1)) begin
              data_q  <= sreg_q[DATA_W-1];
              sreg_q  <= sreg_q << 1;
              bit_q   <= BIT_W'(DATA_W - 1);
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          if (cs_off) begin
            err_q   <= 1'b1;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (clk_fall) begin
            if (bit_q == '0) begin
              data_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              data_q <= sreg_q[DATA_W-1];
              sreg_q <= sreg_q << 1;
              bit_q  <= bit_q - BIT_W'(1);
            end
          end
        end
        ST_DONE: begin
          data_q <= 1'b0;
          if (cs_off) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          data_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign DATA_Out    = data_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_error = err_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Self-checking bench for adc_serial_responder.
// Acts as the ADC reader: drives CS/ADC_clk, samples on rises.
module tb_adc_serial_responder;

  logic       clk;
  logic       reset;
  logic       ADC_clk;
  logic       CS;
  logic [9:0] sample_in;
  logic       DATA_Out;
  logic       busy;
  logic       frame_done;
  logic       frame_error;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic exp_q[$];

  adc_serial_responder dut (
    .clk         (clk),
    .reset       (reset),
    .ADC_clk     (ADC_clk),
    .CS          (CS),
    .sample_in   (sample_in),
    .DATA_Out    (DATA_Out),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_error (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse-high cycle counts; a 1-clk pulse adds exactly one.
  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_error === 1'b1) err_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One ADC_clk period: rise (master samples), then fall.
  task automatic adc_cycle(output logic s);
    ADC_clk = 1'b1;
    s = DATA_Out;
    wait_clk(8);
    ADC_clk = 1'b0;
    wait_clk(8);
  endtask

  // Expected rise samples: null bit, 8 data bits MSB first, 0.
  task automatic push_frame(input logic [7:0] v);
    exp_q.push_back(1'b0);
    for (int i = 7; i >= 0; i--)
      exp_q.push_back(v[i]);
    exp_q.push_back(1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ADC_clk = ~ADC_clk;
      CS = ~CS;
      n_checks++;
      if (DATA_Out !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_data: got %b want 0", DATA_Out);
      end
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_busy: got %b want 0", busy);
      end
      n_checks++;
      if (frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_done: got %b want 0", frame_done);
      end
      n_checks++;
      if (frame_error !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_err: got %b want 0", frame_error);
      end
    end
    ADC_clk = 1'b0;
    CS = 1'b1;
    wait_clk(2);
    reset = 1'b1;
    wait_clk(8);
    n_checks++;
    if (done_cnt !== 0 || err_cnt !== 0) begin
      n_fail++;
      $display("FAIL rst_pulses: done %0d err %0d want 0 0",
               done_cnt, err_cnt);
    end
  endtask

  task automatic test_frame;
    logic s, e;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    push_frame(8'hB5);
    sample_in = 10'h2D4;
    CS = 1'b0;
    wait_clk(16);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL frm_busy: got %b want 1", busy);
    end
    for (int i = 0; i < 10; i++) begin
      adc_cycle(s);
      e = exp_q.pop_front();
      n_checks++;
      if (s !== e) begin
        n_fail++;
        $display("FAIL frm_bit%0d: got %b want %b", i, s, e);
      end
    end
    CS = 1'b1;
    wait_clk(8);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frm_busy_end: got %b want 0", busy);
    end
    n_checks++;
    if (done_cnt !== d0 + 1) begin
      n_fail++;
      $display("FAIL frm_done: got %0d want %0d",
               done_cnt - d0, 1);
    end
    n_checks++;
    if (err_cnt !== e0) begin
      n_fail++;
      $display("FAIL frm_err: got %0d want 0", err_cnt - e0);
    end
  endtask

  task automatic test_abort;
    logic s, e;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    sample_in = 10'h2D4;
    CS = 1'b0;
    wait_clk(16);
    for (int i = 0; i < 4; i++) begin
      adc_cycle(s);
      e = exp_q.pop_front();
      n_checks++;
      if (s !== e) begin
        n_fail++;
        $display("FAIL abt_bit%0d: got %b want %b", i, s, e);
      end
    end
    ADC_clk = 1'b1;
    s = DATA_Out;
    e = exp_q.pop_front();
    n_checks++;
    if (s !== e) begin
      n_fail++;
      $display("FAIL abt_bit4: got %b want %b", s, e);
    end
    wait_clk(8);
    CS = 1'b1;
    wait_clk(6);
    n_checks++;
    if (err_cnt !== e0 + 1) begin
      n_fail++;
      $display("FAIL abt_err: got %0d want 1", err_cnt - e0);
    end
    n_checks++;
    if (done_cnt !== d0) begin
      n_fail++;
      $display("FAIL abt_done: got %0d want 0", done_cnt - d0);
    end
    n_checks++;
    if (DATA_Out !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abt_idle: data %b busy %b want 0 0",
               DATA_Out, busy);
    end
    ADC_clk = 1'b0;
    wait_clk(16);
    n_checks++;
    if (err_cnt !== e0 + 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abt_quiet: err %0d busy %b want 1 0",
               err_cnt - e0, busy);
    end
  endtask

  task automatic test_sample_hold;
    logic s, e;
    int d0;
    d0 = done_cnt;
    push_frame(8'h00);
    sample_in = 10'h000;
    CS = 1'b0;
    wait_clk(16);
    sample_in = 10'h3FF;
    for (int i = 0; i < 10; i++) begin
      adc_cycle(s);
      e = exp_q.pop_front();
      n_checks++;
      if (s !== e) begin
        n_fail++;
        $display("FAIL hold0_bit%0d: got %b want %b", i, s, e);
      end
    end
    CS = 1'b1;
    wait_clk(16);
    push_frame(8'hFF);
    CS = 1'b0;
    wait_clk(16);
    for (int i = 0; i < 10; i++) begin
      adc_cycle(s);
      e = exp_q.pop_front();
      n_checks++;
      if (s !== e) begin
        n_fail++;
        $display("FAIL holdF_bit%0d: got %b want %b", i, s, e);
      end
    end
    CS = 1'b1;
    wait_clk(8);
    n_checks++;
    if (done_cnt !== d0 + 2) begin
      n_fail++;
      $display("FAIL hold_done: got %0d want 2", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back;
    logic s, e;
    logic [9:0] smp [2];
    int d0, e0;
    smp[0] = 10'h15C;
    smp[1] = 10'h2A3;
    d0 = done_cnt;
    e0 = err_cnt;
    wait_clk(16);
    for (int f = 0; f < 2; f++) begin
      push_frame(smp[f][9:2]);
      sample_in = smp[f];
      CS = 1'b0;
      wait_clk(16);
      for (int i = 0; i < 10; i++) begin
        adc_cycle(s);
        e = exp_q.pop_front();
        n_checks++;
        if (s !== e) begin
          n_fail++;
          $display("FAIL b2b%0d_bit%0d: got %b want %b",
                   f, i, s, e);
        end
      end
      CS = 1'b1;
      wait_clk(16);
    end
    n_checks++;
    if (done_cnt !== d0 + 2 || err_cnt !== e0) begin
      n_fail++;
      $display("FAIL b2b_pulses: done %0d err %0d want 2 0",
               done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_reset_midframe;
    logic s, e;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    sample_in = 10'h2D4;
    CS = 1'b0;
    wait_clk(16);
    for (int i = 0; i < 3; i++) begin
      adc_cycle(s);
      e = exp_q.pop_front();
      n_checks++;
      if (s !== e) begin
        n_fail++;
        $display("FAIL mrst_bit%0d: got %b want %b", i, s, e);
      end
    end
    e = exp_q.pop_front();
    n_checks++;
    if (DATA_Out !== e) begin
      n_fail++;
      $display("FAIL mrst_bit5: got %b want %b", DATA_Out, e);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (DATA_Out !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mrst_clear: data %b busy %b want 0 0",
               DATA_Out, busy);
    end
    CS = 1'b1;
    wait_clk(4);
    reset = 1'b1;
    wait_clk(16);
    n_checks++;
    if (err_cnt !== e0 || done_cnt !== d0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mrst_quiet: err %0d done %0d busy %b want 0 0 0",
               err_cnt - e0, done_cnt - d0, busy);
    end
    push_frame(8'hB5);
    CS = 1'b0;
    wait_clk(16);
    for (int i = 0; i < 10; i++) begin
      adc_cycle(s);
      e = exp_q.pop_front();
      n_checks++;
      if (s !== e) begin
        n_fail++;
        $display("FAIL mrst_next%0d: got %b want %b", i, s, e);
      end
    end
    CS = 1'b1;
    wait_clk(8);
    n_checks++;
    if (done_cnt !== d0 + 1 || err_cnt !== e0) begin
      n_fail++;
      $display("FAIL mrst_pulses: done %0d err %0d want 1 0",
               done_cnt - d0, err_cnt - e0);
    end
  endtask

  initial begin
    reset     = 1'b0;
    ADC_clk   = 1'b0;
    CS        = 1'b1;
    sample_in = '0;
    test_reset();
    test_frame();
    test_abort();
    test_sample_hold();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
